// File: rtl/sipo_deserializer_pkg.sv
// Shared types and constants for the SIPO deserializer: FSM state encoding
// and the bit-order selector values.
package sipo_deserializer_pkg;

  typedef enum logic {
    IDLE,
    RECEIVE
  } state_t;

  localparam int unsigned FIRST_BIT_LSB = 0;
  localparam int unsigned FIRST_BIT_MSB = 1;

endpackage

// File: rtl/sipo_deserializer_8_bit_if.sv
// Serial receive, parallel valid/ready output and error-flag signals of the
// SIPO deserializer, grouped into one bundle.
interface sipo_deserializer_8_bit_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  enable;
  logic                  serial_valid;
  logic                  serial_data;
  logic                  frame_start;
  logic [DATA_WIDTH-1:0] parallel_data;
  logic                  parallel_valid;
  logic                  parallel_ready;
  logic                  overrun_error;
  logic                  framing_error;
  logic                  parity_error;
  logic                  error_clear;

  modport master (
    output enable, serial_valid, serial_data, frame_start, parallel_ready, error_clear,
    input  parallel_data, parallel_valid, overrun_error, framing_error, parity_error
  );

  modport slave (
    input  enable, serial_valid, serial_data, frame_start, parallel_ready, error_clear,
    output parallel_data, parallel_valid, overrun_error, framing_error, parity_error
  );

endinterface

// File: rtl/sipo_output_buffer.sv
// One-entry valid/ready holding register. A load is accepted when the entry
// is empty or being popped in the same cycle; otherwise it is flagged as overrun.
module sipo_output_buffer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  overrun
);

  logic pop;

  assign pop     = valid & ready;
  assign overrun = load & valid & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load && (!valid || pop)) begin
      data  <= word;
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deserializer_8_bit.sv
// Serial-in/parallel-out receiver: framed bit capture FSM, bit counter,
// shift register and sticky error flags. Optional even parity: SIPO_DESERIALIZER_PARITY_EN.
module sipo_deserializer_8_bit #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FIRST_BIT_MSB = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  sipo_deserializer_8_bit_if.slave   bus
);

  import sipo_deserializer_pkg::*;

`ifdef SIPO_DESERIALIZER_PARITY_EN
  localparam int unsigned FRAME_BITS = DATA_WIDTH + 1;
`else
  localparam int unsigned FRAME_BITS = DATA_WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);

  state_t                state, state_n;
  logic [CNT_W-1:0]      count, count_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  accept;
  logic                  word_done;
  logic                  framing_set;
  logic                  overrun_set;
  logic                  overrun_flag;
  logic                  framing_flag;
`ifdef SIPO_DESERIALIZER_PARITY_EN
  logic                  par, par_n;
  logic                  parity_set;
  logic                  parity_flag;
`endif

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] r,
                                                     input logic b);
    if (FIRST_BIT_MSB == sipo_deserializer_pkg::FIRST_BIT_MSB)
      return {r[DATA_WIDTH-2:0], b};
    else
      return {b, r[DATA_WIDTH-1:1]};
  endfunction

  assign accept = bus.enable & bus.serial_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
`ifdef SIPO_DESERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      count <= count_n;
      shreg <= shreg_n;
`ifdef SIPO_DESERIALIZER_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    shreg_n     = shreg;
    word_done   = 1'b0;
    framing_set = 1'b0;
`ifdef SIPO_DESERIALIZER_PARITY_EN
    par_n       = par;
    parity_set  = 1'b0;
`endif
    if (accept) begin
      if (bus.frame_start) begin
        state_n     = RECEIVE;
        count_n     = CNT_W'(1);
        shreg_n     = shift_in('0, bus.serial_data);
        framing_set = (state == RECEIVE);
`ifdef SIPO_DESERIALIZER_PARITY_EN
        par_n       = bus.serial_data;
`endif
      end else if (state == RECEIVE) begin
        count_n = count + 1'b1;
        // The trailing parity bit is checked but never shifted into the word
        if (count < DATA_CNT) begin
          shreg_n = shift_in(shreg, bus.serial_data);
`ifdef SIPO_DESERIALIZER_PARITY_EN
          par_n   = par ^ bus.serial_data;
`endif
        end
        if (count_n == LAST_CNT) begin
          state_n = IDLE;
          count_n = '0;
`ifdef SIPO_DESERIALIZER_PARITY_EN
          word_done  = ~(par ^ bus.serial_data);
          parity_set = par ^ bus.serial_data;
`else
          word_done  = 1'b1;
`endif
        end
      end
    end
  end

  sipo_output_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (word_done),
    .word   (shreg_n),
    .ready  (bus.parallel_ready),
    .data   (bus.parallel_data),
    .valid  (bus.parallel_valid),
    .overrun(overrun_set)
  );

  // Sticky flags: a set in the same cycle as a clear takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_flag <= 1'b0;
      framing_flag <= 1'b0;
`ifdef SIPO_DESERIALIZER_PARITY_EN
      parity_flag  <= 1'b0;
`endif
    end else begin
      overrun_flag <= overrun_set | (overrun_flag & ~bus.error_clear);
      framing_flag <= framing_set | (framing_flag & ~bus.error_clear);
`ifdef SIPO_DESERIALIZER_PARITY_EN
      parity_flag  <= parity_set | (parity_flag & ~bus.error_clear);
`endif
    end
  end

  assign bus.overrun_error = overrun_flag;
  assign bus.framing_error = framing_flag;
`ifdef SIPO_DESERIALIZER_PARITY_EN
  assign bus.parity_error  = parity_flag;
`else
  assign bus.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer_8_bit.sv
// Scoreboard bench for sipo_deserializer_8_bit: an MSB-first and an LSB-first
// instance receive the same serial stream; a monitor checks every popped word.
module tb_sipo_deserializer_8_bit;

`ifdef SIPO_DESERIALIZER_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] exp_m[$];
  logic [7:0] exp_l[$];

  sipo_deserializer_8_bit_if #(.DATA_WIDTH(8)) if_m ();
  sipo_deserializer_8_bit_if #(.DATA_WIDTH(8)) if_l ();

  sipo_deserializer_8_bit #(.DATA_WIDTH(8), .FIRST_BIT_MSB(1)) dut_msb (
    .clk(clk), .rst(rst), .bus(if_m)
  );
  sipo_deserializer_8_bit #(.DATA_WIDTH(8), .FIRST_BIT_MSB(0)) dut_lsb (
    .clk(clk), .rst(rst), .bus(if_l)
  );

  assign if_l.enable         = if_m.enable;
  assign if_l.serial_valid   = if_m.serial_valid;
  assign if_l.serial_data    = if_m.serial_data;
  assign if_l.frame_start    = if_m.frame_start;
  assign if_l.parallel_ready = if_m.parallel_ready;
  assign if_l.error_clear    = if_m.error_clear;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%02h required=0x%02h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake of each instance
  always @(negedge clk) begin
    if (!rst && if_m.parallel_valid && if_m.parallel_ready) begin
      if (exp_m.size() == 0) check("msb_unexpected_word", if_m.parallel_data, 8'hxx);
      else check("msb_word", if_m.parallel_data, exp_m.pop_front());
    end
    if (!rst && if_l.parallel_valid && if_l.parallel_ready) begin
      if (exp_l.size() == 0) check("lsb_unexpected_word", if_l.parallel_data, 8'hxx);
      else check("lsb_word", if_l.parallel_data, exp_l.pop_front());
    end
  end

  task automatic push(input logic [7:0] m, input logic [7:0] l);
    exp_m.push_back(m);
    exp_l.push_back(l);
  endtask

  // Sends the first nbits of w, MSB first, framed; full frames get a parity bit
  // when enabled. pause_at>0 inserts ignored strobes with Enable low before that bit.
  task automatic send_frame(input logic [7:0] w, input int unsigned nbits,
                            input bit raise_ready, input bit flip,
                            input int unsigned pause_at);
    int unsigned total;
    logic        pbit;
    pbit  = (^w) ^ flip;
    total = nbits + ((PARITY && nbits == 8) ? 1 : 0);
    for (int unsigned i = 0; i < total; i++) begin
      if (pause_at != 0 && i == pause_at) begin
        if_m.enable       = 1'b0;
        if_m.serial_valid = 1'b1;
        if_m.frame_start  = 1'b1;
        if_m.serial_data  = ~w[7-i];
        repeat (2) begin @(posedge clk); #1; end
        if_m.enable = 1'b1;
      end
      if_m.serial_valid = 1'b1;
      if_m.frame_start  = (i == 0);
      if_m.serial_data  = (i < nbits) ? w[7-i] : pbit;
      if (raise_ready && i == total - 1) if_m.parallel_ready = 1'b1;
      @(posedge clk); #1;
    end
    if_m.serial_valid = 1'b0;
    if_m.frame_start  = 1'b0;
    if_m.serial_data  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_msb_valid"},   {7'd0, if_m.parallel_valid}, 8'h00);
    check({tag, "_msb_data"},    if_m.parallel_data, 8'h00);
    check({tag, "_msb_overrun"}, {7'd0, if_m.overrun_error}, 8'h00);
    check({tag, "_msb_framing"}, {7'd0, if_m.framing_error}, 8'h00);
    check({tag, "_msb_parity"},  {7'd0, if_m.parity_error}, 8'h00);
    check({tag, "_lsb_valid"},   {7'd0, if_l.parallel_valid}, 8'h00);
    check({tag, "_lsb_data"},    if_l.parallel_data, 8'h00);
  endtask

  task automatic pulse_clear();
    if_m.error_clear = 1'b1;
    @(posedge clk); #1;
    if_m.error_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_m.enable = 1'b1; if_m.serial_valid = 1'b0; if_m.serial_data = 1'b0;
    if_m.frame_start = 1'b0; if_m.parallel_ready = 1'b0; if_m.error_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single frame, valid high for exactly one cycle
    if_m.parallel_ready = 1'b1;
    push(8'hA5, 8'hA5);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 0);
    check("a5_valid_after_last_bit", {7'd0, if_m.parallel_valid}, 8'h01);
    @(posedge clk); #1;
    check("a5_valid_one_cycle", {7'd0, if_m.parallel_valid}, 8'h00);

    // Bit order: 0xD0 MSB first is 0x0B LSB first
    push(8'hD0, 8'h0B);
    send_frame(8'hD0, 8, 1'b0, 1'b0, 0);

    // Back-to-back frames with no gap
    push(8'h3C, 8'h3C);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 0);
    push(8'h96, 8'h69);
    send_frame(8'h96, 8, 1'b0, 1'b0, 0);

    // Enable low mid-frame pauses the frame; strobes meanwhile are ignored
    push(8'h5A, 8'h5A);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 4);
    @(posedge clk); #1;

    // Overrun with a stalled consumer
    if_m.parallel_ready = 1'b0;
    push(8'h11, 8'h88);
    send_frame(8'h11, 8, 1'b0, 1'b0, 0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    check("overrun_msb_flag", {7'd0, if_m.overrun_error}, 8'h01);
    check("overrun_lsb_flag", {7'd0, if_l.overrun_error}, 8'h01);
    check("overrun_msb_kept", if_m.parallel_data, 8'h11);
    check("overrun_lsb_kept", if_l.parallel_data, 8'h88);
    pulse_clear();
    check("overrun_cleared", {7'd0, if_m.overrun_error}, 8'h00);
    push(8'h33, 8'hCC);
    send_frame(8'h33, 8, 1'b1, 1'b0, 0);
    check("pop_load_valid", {7'd0, if_m.parallel_valid}, 8'h01);
    check("pop_load_no_overrun", {7'd0, if_m.overrun_error}, 8'h00);
    @(posedge clk); #1;

    // Framing: a new frame start after three bits
    send_frame(8'hE0, 3, 1'b0, 1'b0, 0);
    push(8'hC3, 8'hC3);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 0);
    check("framing_flag", {7'd0, if_m.framing_error}, 8'h01);
    check("framing_data", if_m.parallel_data, 8'hC3);
    check("framing_no_overrun", {7'd0, if_m.overrun_error}, 8'h00);
    pulse_clear();
    check("framing_cleared", {7'd0, if_m.framing_error}, 8'h00);

    // Asynchronous reset mid-frame with the buffer full and an overrun flagged
    if_m.parallel_ready = 1'b0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 0);
    send_frame(8'hF0, 3, 1'b0, 1'b0, 0);
    check("pre_reset_overrun", {7'd0, if_m.overrun_error}, 8'h01);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    if_m.parallel_ready = 1'b1;
    push(8'h69, 8'h96);
    send_frame(8'h69, 8, 1'b0, 1'b0, 0);
    check("post_reset_data", if_m.parallel_data, 8'h69);

`ifdef SIPO_DESERIALIZER_PARITY_EN
    // Wrong parity bit drops the word; correct one delivers it
    @(posedge clk); #1;
    send_frame(8'hA5, 8, 1'b0, 1'b1, 0);
    check("parity_bad_no_valid", {7'd0, if_m.parallel_valid}, 8'h00);
    check("parity_bad_flag", {7'd0, if_m.parity_error}, 8'h01);
    pulse_clear();
    check("parity_cleared", {7'd0, if_m.parity_error}, 8'h00);
    push(8'hA5, 8'hA5);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 0);
    check("parity_good_valid", {7'd0, if_m.parallel_valid}, 8'h01);
    check("parity_good_flag", {7'd0, if_m.parity_error}, 8'h00);
`else
    check("parity_tied_low", {7'd0, if_m.parity_error}, 8'h00);
`endif

    repeat (3) begin @(posedge clk); #1; end
    check("msb_scoreboard_drained", 8'(exp_m.size()), 8'h00);
    check("lsb_scoreboard_drained", 8'(exp_l.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer_8_bit.md
# sipo_deserializer_8_bit

Serial-in/parallel-out receiver that reassembles framed serial bit streams, as produced by the universal shift register in shift mode, into parallel words. The block captures strobed bits into a shift register and counts them against the word width. Each complete word is handed to a one-entry output buffer that uses a valid/ready handshake. It sits at the receive end of a serial link; the upstream shift register serializes and this block deserializes.

## Interface
- DATA_WIDTH, 8, word width in bits; legal range is 2 and up.
- FIRST_BIT_MSB, 1, bit order: 1 means the first received bit lands in bit [DATA_WIDTH-1] (matches left-shift transmit); 0 means the first bit lands in bit [0].

Ports:
- Clk_In  in  1  clock; everything is on the rising edge.
- Reset_In  in  1  asynchronous, active-high reset.
- Enable_In  in  1  bit capture enable; when low, serial strobes are ignored and receive state holds.
- Serial_Valid_In  in  1  serial bit strobe; Serial_Data_In and Frame_Start_In are sampled only when this is high.
- Serial_Data_In  in  1  serial data bit.
- Frame_Start_In  in  1  marks the current strobed bit as the first bit of a word.
- Parallel_Data_Out  out  DATA_WIDTH  received word; stable while Parallel_Valid_Out is high.
- Parallel_Valid_Out  out  1  output buffer full.
- Parallel_Ready_In  in  1  consumer accepts the word.
- Overrun_Error_Out  out  1  sticky; a completed word was dropped because the buffer was full.
- Framing_Error_Out  out  1  sticky; a frame restarted before it completed.
- Parity_Error_Out  out  1  sticky; see Configuration.
- Error_Clear_In  in  1  synchronous clear of all sticky errors.

## Operation
- States are IDLE and RECEIVE, with a bit counter of width $clog2(DATA_WIDTH+1).
- A strobe counts as "accepted" when Enable_In & Serial_Valid_In.
- IDLE:
  - Accepted bit with Frame_Start_In=1 loads bit 1, sets count=1 and goes to RECEIVE.
  - Accepted bit without Frame_Start_In is discarded with no error.
- RECEIVE:
  - Each accepted bit shifts in and increments the count.
  - On FIRST_BIT_MSB=1 the register shifts left, inserting at [0]. On 0 it shifts right, inserting at [DATA_WIDTH-1].
  - Accepted bit with Frame_Start_In=1 sets Framing_Error_Out and restarts the frame with this bit as bit 1 (count=1).
  - The accepted bit that brings the count to DATA_WIDTH completes the word, and the state returns to IDLE.
- On word complete:
  - If the buffer is empty, or is popped in the same cycle, the word loads and Parallel_Valid_Out=1.
  - Otherwise the word is dropped, Overrun_Error_Out=1, and the buffer keeps the old word.
- Pop happens when Parallel_Valid_Out & Parallel_Ready_In. With no simultaneous load, Parallel_Valid_Out goes to 0 on the next edge.
- The output handshake is independent of Enable_In.
- Error_Clear_In clears the sticky errors. If an error set and a clear occur in the same cycle, the set wins.

## Timing
- Reset values:
  - All outputs are 0: Parallel_Data_Out=0, Parallel_Valid_Out=0, and all error flags 0.
  - State is IDLE, the count is 0 and the shift register is 0.
- Latency: the word is visible on the edge that samples its last bit, so Parallel_Valid_Out is high in the following cycle.
- Throughput is one bit per cycle. With Parallel_Ready_In held high, back-to-back frames have no gaps.
- A Reset_In assertion mid-frame aborts the frame and empties the buffer immediately, without waiting for a clock edge.
- An Enable_In low pulse mid-frame pauses the count; the frame resumes when Enable_In returns high.

## Configuration
- SIPO_DESERIALIZER_PARITY_EN defined:
  - Each frame is DATA_WIDTH data bits followed by one even-parity bit; completion happens at count DATA_WIDTH+1.
  - On a parity mismatch the word is discarded (not loaded) and Parity_Error_Out is set.
  - The counter width grows to cover DATA_WIDTH+1.
- Undefined: there is no parity bit and Parity_Error_Out is tied to 0.

## Structure
- Package sipo_deserializer_pkg holds:
  - the state enum (IDLE, RECEIVE);
  - the bit-order localparams FIRST_BIT_LSB=0 and FIRST_BIT_MSB=1.
- One sub-module, sipo_output_buffer: the one-entry valid/ready holding register with load, pop and overrun detection.
- The top level holds the FSM, the counter, the shift register and the error flags.

## Test plan
All scenarios use DATA_WIDTH=8.
- Reset: assert Reset_In mid-frame with the buffer full -> every output reads 0 and state is IDLE; the next frame decodes correctly.
- MSB first: Frame_Start with bits 1,0,1,0,0,1,0,1, Ready held 1 -> 0xA5 with Parallel_Valid_Out high for exactly one cycle after the 8th bit.
- FIRST_BIT_MSB=0: bits 1,1,0,1,0,0,0,0 -> 0x0B (the same bits with MSB first give 0xD0).
- Overrun: Ready=0, send 0x11 then 0x22 -> output stays 0x11 and Overrun_Error_Out=1. Pulse Error_Clear_In -> flag returns to 0. Raise Ready in the cycle 0x33 completes -> 0x33 loads with no overrun.
- Framing: 3 bits, then Frame_Start with 0xC3 -> Framing_Error_Out=1 and Parallel_Data_Out=0xC3.
- Parity (macro on): 0xA5 with parity bit 1 -> no word delivered and Parity_Error_Out=1. With parity bit 0 -> 0xA5 delivered.
